// File: rtl/pc_sel_arbiter.sv
// Round-robin 6:1 select arbiter for the hring fan-in mux.
// Define PC_SEL_ARB_LOCK_EN to hold the grant across multi-flit packets.
`ifndef PC_INDEX_WIDTH
`define PC_INDEX_WIDTH 3
`endif

module pc_sel_arbiter #(
  parameter int N_IN  = 6,
  parameter int SEL_W = `PC_INDEX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req,
  input  logic [N_IN-1:0]  tail,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic [N_IN-1:0]  gnt
);

`ifdef PC_SEL_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, OFFER, LOCKED} state_t;
`else
  typedef enum logic [1:0] {IDLE, OFFER} state_t;
`endif

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] owner;
  logic [SEL_W-1:0] nptr;
  logic             xfer;
  logic             last;
  logic             idle_hit;
  logic [SEL_W-1:0] idle_w;
  logic             rel_hit;
  logic [SEL_W-1:0] rel_w;

  // First set bit of r scanning p, p+1, ... modulo N_IN.
  function automatic logic [SEL_W:0] pick(
    input logic [N_IN-1:0]  r,
    input logic [SEL_W-1:0] p
  );
    logic             found;
    logic [SEL_W-1:0] w;
    logic [SEL_W-1:0] i3;
    int               idx;
    found = 1'b0;
    w     = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx = int'(p) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      i3 = SEL_W'(idx);
      if (!found && r[i3]) begin
        found = 1'b1;
        w     = i3;
      end
    end
    return {found, w};
  endfunction

  function automatic logic [N_IN-1:0] onehot(
    input logic [SEL_W-1:0] w
  );
    return N_IN'(1) << w;
  endfunction

  always_comb begin
    nptr = (owner == SEL_W'(N_IN - 1)) ? '0 : owner + 1'b1;
    xfer = sel_valid & out_ready;
    {idle_hit, idle_w} = pick(req, ptr);
    {rel_hit, rel_w}   = pick(req, nptr);
    last = 1'b1;
`ifdef PC_SEL_ARB_LOCK_EN
    last = tail[owner];
`endif
  end

`ifndef PC_SEL_ARB_LOCK_EN
  logic unused_tail;
  assign unused_tail = ^tail;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      gnt       <= '0;
    end else if (state != IDLE && xfer && last) begin
      // Packet end: rotate past the owner and re-arbitrate at once.
      ptr <= nptr;
      if (rel_hit) begin
        state     <= OFFER;
        owner     <= rel_w;
        sel       <= rel_w;
        sel_valid <= 1'b1;
        gnt       <= onehot(rel_w);
      end else begin
        state     <= IDLE;
        sel_valid <= 1'b0;
        gnt       <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (idle_hit) begin
            state     <= OFFER;
            owner     <= idle_w;
            sel       <= idle_w;
            sel_valid <= 1'b1;
            gnt       <= onehot(idle_w);
          end
        end
        OFFER: begin
`ifdef PC_SEL_ARB_LOCK_EN
          if (xfer) begin
            state     <= LOCKED;
            sel_valid <= req[owner];
            gnt       <= req[owner] ? onehot(owner) : '0;
          end else
`endif
          if (!req[owner]) begin
            state     <= IDLE;
            sel_valid <= 1'b0;
            gnt       <= '0;
          end
        end
`ifdef PC_SEL_ARB_LOCK_EN
        LOCKED: begin
          sel_valid <= req[owner];
          gnt       <= req[owner] ? onehot(owner) : '0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
